// File: rtl/gmii_frame_monitor.sv
// PHY-side GMII transmit monitor: frame delineation, length, FCS residue check, per-frame status.
// Define GMII_FRAME_MONITOR_CNT_EN to build the saturating frame_cnt / bad_cnt counters.
module gmii_frame_monitor #(
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_PREAMBLE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic        status_valid,
  output logic [15:0] status_len,
  output logic        status_fcs_bad,
  output logic        status_er,
  output logic        status_runt,
  output logic        status_pre_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] bad_cnt
);

  localparam int unsigned PreW       = $clog2(MAX_PREAMBLE + 1);
  localparam logic [PreW-1:0] MaxPre = PreW'(MAX_PREAMBLE);
  localparam logic [15:0] MinLen     = 16'(MIN_LEN);
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StDrop} state_e;

  state_e          state_q;
  logic [31:0]     crc_q;
  logic [15:0]     len_q;
  logic [PreW-1:0] pre_cnt_q;
  logic            er_q;

  // Reflected CRC-32, one byte LSB first, no final inversion.
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      crc_q          <= '0;
      len_q          <= '0;
      pre_cnt_q      <= '0;
      er_q           <= 1'b0;
      status_valid   <= 1'b0;
      status_len     <= '0;
      status_fcs_bad <= 1'b0;
      status_er      <= 1'b0;
      status_runt    <= 1'b0;
      status_pre_err <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gmii_tx_en) begin
            er_q <= gmii_tx_er;
            if (gmii_txd == 8'h55) begin
              state_q   <= StPreamble;
              pre_cnt_q <= PreW'(1);
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StPreamble: begin
          if (!gmii_tx_en) begin
            state_q        <= StIdle;
            status_valid   <= 1'b1;
            status_len     <= '0;
            status_fcs_bad <= 1'b0;
            status_er      <= er_q;
            status_runt    <= 1'b0;
            status_pre_err <= 1'b1;
          end else begin
            er_q <= er_q | gmii_tx_er;
            if (gmii_txd == 8'h55 && pre_cnt_q < MaxPre) begin
              pre_cnt_q <= pre_cnt_q + PreW'(1);
            end else if (gmii_txd == 8'hD5) begin
              state_q <= StPayload;
              crc_q   <= 32'hFFFFFFFF;
              len_q   <= '0;
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StPayload: begin
          if (!gmii_tx_en) begin
            state_q        <= StIdle;
            status_valid   <= 1'b1;
            status_len     <= len_q;
            status_fcs_bad <= (crc_q != CrcResidue);
            status_er      <= er_q;
            status_runt    <= (len_q < MinLen);
            status_pre_err <= 1'b0;
          end else begin
            er_q  <= er_q | gmii_tx_er;
            crc_q <= crc_next(crc_q, gmii_txd);
            if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
          end
        end
        StDrop: begin
          if (!gmii_tx_en) begin
            state_q        <= StIdle;
            status_valid   <= 1'b1;
            status_len     <= '0;
            status_fcs_bad <= 1'b0;
            status_er      <= er_q;
            status_runt    <= 1'b0;
            status_pre_err <= 1'b1;
          end else begin
            er_q <= er_q | gmii_tx_er;
          end
        end
      endcase
    end
  end

`ifdef GMII_FRAME_MONITOR_CNT_EN
  logic        rpt;
  logic        rpt_bad;
  logic [15:0] frame_cnt_q;
  logic [15:0] bad_cnt_q;

  // Counters must move on the same edge as status_valid, so decode the report combinationally.
  always_comb begin
    rpt     = 1'b0;
    rpt_bad = 1'b0;
    if (!gmii_tx_en) begin
      case (state_q)
        StPreamble, StDrop: begin
          rpt     = 1'b1;
          rpt_bad = 1'b1;
        end
        StPayload: begin
          rpt     = 1'b1;
          rpt_bad = er_q | (crc_q != CrcResidue) | (len_q < MinLen);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else if (rpt) begin
      if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (rpt_bad && bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign bad_cnt   = bad_cnt_q;
`else
  assign frame_cnt = 16'h0000;
  assign bad_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_gmii_frame_monitor.sv
// Randomized bench for gmii_frame_monitor: each tx_en burst is judged as a whole by a frame-level model.
module tb_gmii_frame_monitor;

  localparam int MinLen = 64;
  localparam int MaxPre = 7;

  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];
  typedef struct packed {
    logic [15:0] len;
    logic        fcs_bad;
    logic        er;
    logic        runt;
    logic        pre_err;
  } st_t;
  typedef struct {
    int  due;
    st_t s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gmii_txd = 8'h00;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_er = 1'b0;
  logic        status_valid;
  logic [15:0] status_len;
  logic        status_fcs_bad;
  logic        status_er;
  logic        status_runt;
  logic        status_pre_err;
  logic [15:0] frame_cnt;
  logic [15:0] bad_cnt;

  gmii_frame_monitor #(
    .MIN_LEN      (MinLen),
    .MAX_PREAMBLE (MaxPre)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .status_valid   (status_valid),
    .status_len     (status_len),
    .status_fcs_bad (status_fcs_bad),
    .status_er      (status_er),
    .status_runt    (status_runt),
    .status_pre_err (status_pre_err),
    .frame_cnt      (frame_cnt),
    .bad_cnt        (bad_cnt)
  );

  always #4 clk = ~clk;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] tbl [256];
  exp_t        exp_q[$];
  st_t         cur = '0;
  int          m_frames = 0;
  int          m_bad = 0;
  bit          ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    return tbl[c[7:0] ^ d] ^ (c >> 8);
  endfunction

  // Frame-level reference: classify the whole burst from its byte list.
  function automatic st_t model(input byte_q_t b, input bit_q_t e);
    st_t         s;
    int          n;
    int          cnt;
    logic [31:0] c;
    s = '0;
    foreach (e[k]) if (e[k]) s.er = 1'b1;
    n = 0;
    while (n < b.size() && b[n] == 8'h55) n++;
    if (n == 0 || n > MaxPre || n >= b.size() || b[n] != 8'hD5) begin
      s.pre_err = 1'b1;
      return s;
    end
    c = 32'hFFFFFFFF;
    for (int k = n + 1; k < b.size(); k++) c = crc_step(c, b[k]);
    cnt       = b.size() - n - 1;
    s.len     = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    s.fcs_bad = (c != 32'hDEBB20E3);
    s.runt    = (cnt < MinLen);
    return s;
  endfunction

  function automatic byte_q_t mk_frame(input int npre, input int ndata);
    byte_q_t     q;
    logic [31:0] c;
    logic [7:0]  d;
    q = {};
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < ndata; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      c = crc_step(c, d);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
    return q;
  endfunction

  function automatic bit_q_t zeros(input int n);
    bit_q_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(1'b0);
    return q;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input bit e);
    @(posedge clk);
    #1;
    gmii_tx_en = 1'b1;
    gmii_txd   = b;
    gmii_tx_er = e;
  endtask

  // tx_er is randomized while tx_en is low; it must never raise a flag.
  task automatic drive_idle();
    @(posedge clk);
    #1;
    gmii_tx_en = 1'b0;
    gmii_txd   = 8'($urandom);
    gmii_tx_er = 1'($urandom);
  endtask

  task automatic end_burst(input byte_q_t b, input bit_q_t e, input int gap);
    exp_t x;
    drive_idle();
    x.due = cyc + 1;
    x.s   = model(b, e);
    exp_q.push_back(x);
    for (int i = 1; i < gap; i++) drive_idle();
  endtask

  task automatic send(input byte_q_t b, input bit_q_t e, input int gap);
    for (int i = 0; i < b.size(); i++) drive_byte(b[i], e[i]);
    end_burst(b, e, gap);
  endtask

  task automatic check_status(input string tag, input st_t s);
    check({tag, ".len"}, 32'(status_len), 32'(s.len));
    check({tag, ".fcs_bad"}, 32'(status_fcs_bad), 32'(s.fcs_bad));
    check({tag, ".er"}, 32'(status_er), 32'(s.er));
    check({tag, ".runt"}, 32'(status_runt), 32'(s.runt));
    check({tag, ".pre_err"}, 32'(status_pre_err), 32'(s.pre_err));
  endtask

  always @(negedge clk) begin
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("status_valid", 32'(status_valid), 32'(ev));
    if (ev) begin
      cur = exp_q[0].s;
      void'(exp_q.pop_front());
      if (m_frames < 65535) m_frames++;
      if ((cur.fcs_bad | cur.er | cur.runt | cur.pre_err) && m_bad < 65535) m_bad++;
    end
    check_status("model", cur);
`ifdef GMII_FRAME_MONITOR_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check("bad_cnt", 32'(bad_cnt), 32'(m_bad));
`else
    check("frame_cnt", 32'(frame_cnt), 32'h0);
    check("bad_cnt", 32'(bad_cnt), 32'h0);
`endif
  end

  initial begin
    byte_q_t     f;
    byte_q_t     post;
    bit_q_t      e;
    logic [31:0] c;
    int          kind;
    int          n;
    string       ascii;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end
    ascii = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, ascii[i]);
    check("model_crc_check_value", ~c, 32'hCBF43926);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) drive_idle();

    // Good 64-byte frame.
    f = mk_frame(7, 60);
    send(f, zeros(f.size()), 3);
    @(negedge clk);
    check_status("good64", '{len: 16'd64, fcs_bad: 1'b0, er: 1'b0, runt: 1'b0, pre_err: 1'b0});

    // Data byte 10 flipped.
    f = mk_frame(7, 60);
    f[18] = f[18] ^ 8'h01;
    send(f, zeros(f.size()), 3);
    @(negedge clk);
    check_status("flip", '{len: 16'd64, fcs_bad: 1'b1, er: 1'b0, runt: 1'b0, pre_err: 1'b0});

    // tx_er on data byte 20.
    f = mk_frame(7, 60);
    e = zeros(f.size());
    e[28] = 1'b1;
    send(f, e, 3);
    @(negedge clk);
    check_status("tx_er", '{len: 16'd64, fcs_bad: 1'b0, er: 1'b1, runt: 1'b0, pre_err: 1'b0});

    // Short good frame.
    f = mk_frame(7, 28);
    send(f, zeros(f.size()), 3);
    @(negedge clk);
    check_status("runt32", '{len: 16'd32, fcs_bad: 1'b0, er: 1'b0, runt: 1'b1, pre_err: 1'b0});

    // Over-long preamble, then a good frame after one idle cycle.
    f = {};
    for (int i = 0; i < 8; i++) f.push_back(8'h55);
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom));
    send(f, zeros(f.size()), 1);
    f = mk_frame(7, 60);
    send(f, zeros(f.size()), 3);
    @(negedge clk);
    check_status("after_pre", '{len: 16'd64, fcs_bad: 1'b0, er: 1'b0, runt: 1'b0, pre_err: 1'b0});

    // Reset at byte 30; the post-reset remainder is a burst of its own.
    f = mk_frame(7, 60);
    f[34] = 8'h12;
    post = {};
    for (int i = 0; i < f.size(); i++) begin
      drive_byte(f[i], 1'b0);
      if (i == 30) begin
        rst = 1'b1;
        exp_q.delete();
        cur      = '0;
        m_frames = 0;
        m_bad    = 0;
      end
      if (i == 33) begin
        @(negedge clk);
        check("reset_len", 32'(status_len), 32'h0);
        check("reset_valid", 32'(status_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      if (i >= 34) post.push_back(f[i]);
    end
    end_burst(post, zeros(post.size()), 3);
    @(negedge clk);
    check_status("post_reset", '{len: 16'd0, fcs_bad: 1'b0, er: 1'b0, runt: 1'b0, pre_err: 1'b1});

    // Randomized mix of frame shapes.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: f = mk_frame(7, $urandom_range(0, 80));
        1: begin
          f = mk_frame($urandom_range(1, 7), $urandom_range(1, 80));
          n = $urandom_range(8, f.size() - 1);
          f[n] = f[n] ^ 8'(1 << $urandom_range(0, 7));
        end
        2: f = mk_frame(7, $urandom_range(40, 80));
        3: begin
          f = {};
          n = $urandom_range(0, 9);
          for (int i = 0; i < n; i++) f.push_back(8'h55);
          f.push_back(($urandom_range(0, 1) == 1) ? 8'hD5 : 8'($urandom));
          for (int i = 0; i < $urandom_range(0, 20); i++) f.push_back(8'($urandom));
        end
        4: begin
          f = mk_frame(7, $urandom_range(0, 30));
          n = $urandom_range(1, f.size());
          while (f.size() > n) void'(f.pop_back());
        end
        default: begin
          f = {};
          for (int i = 0; i < $urandom_range(1, 20); i++) f.push_back(8'($urandom));
        end
      endcase
      e = zeros(f.size());
      if (kind == 2) foreach (e[k]) e[k] = ($urandom_range(0, 15) == 0);
      send(f, e, $urandom_range(1, 3));
    end

    repeat (4) drive_idle();
    @(negedge clk);
    check("expectations_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_frame_monitor.md
# gmii_frame_monitor

PHY-side GMII transmit monitor: observes the MAC's GMII transmit bus (gmii_txd/gmii_tx_en/gmii_tx_er) the same way the PHY consumes it. It delineates each frame by preamble and SFD, counts bytes, checks the Ethernet FCS, and reports one status word per frame. It is used in loopback benches and on-board self-test in the 125 MHz core domain, alongside the MAC that drives phy_txd.

## Interface
- MIN_LEN, 64: frame length (bytes after SFD, FCS included) below which status_runt is set.
- MAX_PREAMBLE, 7: maximum number of 0x55 bytes accepted before the SFD.
- clk  input  1  GMII transmit clock, 125 MHz.
- rst  input  1  reset; asynchronous, active-high.
- gmii_txd  input  8  transmit data.
- gmii_tx_en  input  1  transmit enable.
- gmii_tx_er  input  1  transmit error.
- status_valid  output  1  one-cycle pulse; the status fields are valid in that cycle.
- status_len  output  16  bytes after SFD including FCS; saturates at 0xFFFF.
- status_fcs_bad  output  1  FCS residue mismatch.
- status_er  output  1  gmii_tx_er seen while gmii_tx_en was high.
- status_runt  output  1  status_len < MIN_LEN.
- status_pre_err  output  1  preamble or SFD violation.
- frame_cnt  output  16  count of frames reported; saturating.
- bad_cnt  output  16  count of frames with any error flag set; saturating.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, DROP.
- IDLE:
  - gmii_tx_en=1 with txd=0x55: go to PREAMBLE, pre_cnt=1.
  - gmii_tx_en=1 with any other txd: set pre_err, go to DROP.
- PREAMBLE:
  - txd=0x55 and pre_cnt<MAX_PREAMBLE: pre_cnt++.
  - txd=0xD5: go to PAYLOAD; crc=0xFFFFFFFF, len=0.
  - Any other byte, or a (MAX_PREAMBLE+1)th 0x55: set pre_err, go to DROP.
  - gmii_tx_en=0: report with pre_err=1, len=0; go to IDLE.
- PAYLOAD:
  - Each byte with gmii_tx_en=1 updates the CRC (reflected polynomial 0xEDB88320, LSB first) and increments len.
  - gmii_tx_en=0: report, go to IDLE.
  - fcs_bad = (crc != 0xDEBB20E3), where 0xDEBB20E3 is the residue after the FCS bytes.
- DROP: consume bytes until gmii_tx_en=0, then report (pre_err=1, len=0, fcs_bad=0) and go to IDLE.
- gmii_tx_er with gmii_tx_en=1 in any non-IDLE state, or on the IDLE entry byte, sets the er flag. gmii_tx_er with gmii_tx_en=0 (carrier extension/idle) is ignored.
- Report: drive the status fields from the per-frame flags; increment frame_cnt; increment bad_cnt if fcs_bad|er|runt|pre_err. Per-frame flags clear on the next frame start.
- runt is evaluated only for frames that reach PAYLOAD; it is 0 when pre_err=1.
- len saturates at 0xFFFF; the CRC keeps running.

## Timing
- Inputs are sampled on the rising edge of clk; there is no input register stage.
- status_valid rises on the edge that samples gmii_tx_en=0 after a frame (the first idle byte) and is high for exactly one cycle.
- The status fields hold their values until the next report. frame_cnt and bad_cnt update on the same edge as status_valid.
- Back-to-back frames with a single idle cycle: the report and IDLE occur on that idle edge. A frame start on the following edge is accepted normally.
- Asserting rst asynchronously clears everything to 0 and the state to IDLE: status_valid, all status fields, frame_cnt, bad_cnt, crc, len, pre_cnt.
- Reset mid-frame: no status is produced for the aborted frame. If gmii_tx_en is still high after reset deasserts, the first sampled non-0x55 byte leads to DROP and a pre_err report.

## Configuration
- GMII_FRAME_MONITOR_CNT_EN:
  - Defined: frame_cnt and bad_cnt are implemented as described.
  - Undefined: both outputs are tied to 16'h0000 and no counter logic is built. Status reporting is unaffected.

## Test plan
- Good frame: 7×0x55, 0xD5, 60 data bytes, correct 4-byte FCS, tx_en low -> one status_valid with len=64, all flags 0, frame_cnt=1, bad_cnt=0.
- Same frame with data byte 10 flipped -> len=64, fcs_bad=1, bad_cnt=1.
- gmii_tx_er pulsed for one cycle at byte 20 of a good frame -> er=1, fcs_bad=0; tx_er pulsed while tx_en=0 -> no flag.
- Good 32-byte frame (28 data bytes + FCS) -> len=32, runt=1, fcs_bad=0.
- 8×0x55 then data -> pre_err=1, len=0, bad_cnt increments; a following good frame after 1 idle cycle -> reported clean.
- rst asserted at byte 30 of a frame, released with tx_en still high -> all outputs 0 during reset, then one pre_err report when tx_en drops, frame_cnt=1.
